// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional feature: define ILLEGAL_OP_TRAP_EN to trap unsupported opcodes in TRAP instead of treating them as NOPs.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] ALUOp,
    output logic [1:0] imm_src,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_t cur_state;
    state_t nxt_state;
    logic   pc_update;
    logic   branch;

    always_ff @(posedge clk) begin
        if (rst) cur_state <= FETCH;
        else     cur_state <= nxt_state;
    end

    // Cache handshake: mem_req (with mem_write/adr_src) is held constant from the
    // first request cycle until the cycle mem_ready=1, which completes the access.
    always_comb begin
        nxt_state  = cur_state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        ALUOp      = 2'b00;
        case (cur_state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    nxt_state = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: nxt_state = MEMADR;
                    OP_RTYPE:     nxt_state = EXECUTER;
                    OP_ITYPE:     nxt_state = EXECUTEI;
                    OP_JAL:       nxt_state = JAL;
                    OP_BEQ:       nxt_state = BEQ;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      nxt_state = TRAP;
`else
                    default:      nxt_state = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                nxt_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) nxt_state = MEMWB;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) nxt_state = FETCH;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                nxt_state  = FETCH;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                ALUOp     = 2'b10;
                nxt_state = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                ALUOp     = 2'b10;
                nxt_state = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                nxt_state = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                nxt_state = ALUWB;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                ALUOp     = 2'b01;
                branch    = 1'b1;
                nxt_state = FETCH;
            end
            TRAP:    nxt_state = TRAP;
            default: nxt_state = FETCH;
        endcase

        // Reset kills every side effect in the same cycle, including a stalled store.
        if (rst) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_update = 1'b0;
            branch    = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign pc_write = pc_update | (branch & zero);
    assign state    = cur_state;

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal = (cur_state == TRAP) && !rst;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller: inputs change just after the falling edge,
// outputs are compared 1 ns later, well away from the rising edge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] ALUOp;
    logic [1:0] imm_src;
    logic       illegal;
    logic [3:0] state;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .ALUOp(ALUOp), .imm_src(imm_src), .illegal(illegal), .state(state)
    );

    task automatic test_reset();
        rst = 1'b1; op = 7'd0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk); #1;
        tests++; if (state !== 4'd0) begin failed++; $display("FAIL reset_state got %0d exp 0", state); end
        tests++; if (mem_req !== 1'b0) begin failed++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        tests++; if ({ir_write, pc_write, reg_write, mem_write} !== 4'b0000) begin
            failed++; $display("FAIL reset_enables got %b exp 0000", {ir_write, pc_write, reg_write, mem_write}); end
        tests++; if (illegal !== 1'b0) begin failed++; $display("FAIL reset_illegal got %b exp 0", illegal); end
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0; #1;
        tests++; if (mem_req !== 1'b1) begin failed++; $display("FAIL reset_first_req got %b exp 1", mem_req); end
        tests++; if (ir_write !== 1'b0) begin failed++; $display("FAIL reset_no_ir got %b exp 0", ir_write); end
        @(negedge clk);
    endtask

    task automatic test_lw();
        int exp_st[5] = '{0, 1, 2, 3, 4};
        op = 7'b0000011; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (state !== 4'(exp_st[i])) begin failed++; $display("FAIL lw_state cyc %0d got %0d exp %0d", i, state, exp_st[i]); end
            tests++; if (mem_req !== (i == 0 || i == 3)) begin failed++; $display("FAIL lw_mem_req cyc %0d got %b", i, mem_req); end
            tests++; if (reg_write !== (i == 4)) begin failed++; $display("FAIL lw_reg_write cyc %0d got %b", i, reg_write); end
            if (i == 3) begin
                tests++; if (adr_src !== 1'b1) begin failed++; $display("FAIL lw_adr_src got %b exp 1", adr_src); end
            end
            if (i == 4) begin
                tests++; if (result_src !== 2'b01) begin failed++; $display("FAIL lw_result_src got %b exp 01", result_src); end
            end
            @(negedge clk);
        end
        #1;
        tests++; if (state !== 4'd0) begin failed++; $display("FAIL lw_return got %0d exp 0", state); end
    endtask

    task automatic test_fetch_stall();
        op = 7'b1100011; zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3); #1;
            tests++; if (state !== 4'd0) begin failed++; $display("FAIL stall_state cyc %0d got %0d exp 0", i, state); end
            tests++; if (mem_req !== 1'b1) begin failed++; $display("FAIL stall_mem_req cyc %0d got %b exp 1", i, mem_req); end
            tests++; if (ir_write !== (i == 3)) begin failed++; $display("FAIL stall_ir_write cyc %0d got %b", i, ir_write); end
            tests++; if (pc_write !== (i == 3)) begin failed++; $display("FAIL stall_pc_write cyc %0d got %b", i, pc_write); end
            @(negedge clk);
        end
        mem_ready = 1'b1; #1;
        tests++; if (state !== 4'd1) begin failed++; $display("FAIL stall_decode got %0d exp 1", state); end
        @(negedge clk); #1;
        tests++; if (state !== 4'd10) begin failed++; $display("FAIL stall_beq got %0d exp 10", state); end
        @(negedge clk);
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            op = 7'b1100011; mem_ready = 1'b1; zero = 1'b0; #1;
            tests++; if (state !== 4'd0) begin failed++; $display("FAIL beq_start z%0d got %0d exp 0", z, state); end
            tests++; if (imm_src !== 2'b10) begin failed++; $display("FAIL beq_imm_src got %b exp 10", imm_src); end
            @(negedge clk);
            @(negedge clk);
            zero = (z == 1); #1;
            tests++; if (state !== 4'd10) begin failed++; $display("FAIL beq_state z%0d got %0d exp 10", z, state); end
            tests++; if (ALUOp !== 2'b01) begin failed++; $display("FAIL beq_aluop got %b exp 01", ALUOp); end
            tests++; if (pc_write !== (z == 1)) begin failed++; $display("FAIL beq_pc_write z%0d got %b", z, pc_write); end
            if (z == 1) begin
                zero = 1'b0; #1;
                tests++; if (pc_write !== 1'b0) begin failed++; $display("FAIL beq_zero_follow got %b exp 0", pc_write); end
            end
            @(negedge clk);
        end
        #1;
        tests++; if (state !== 4'd0) begin failed++; $display("FAIL beq_return got %0d exp 0", state); end
    endtask

    task automatic test_rtype();
        int exp_st[4] = '{0, 1, 6, 7};
        op = 7'b0110011; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (state !== 4'(exp_st[i])) begin failed++; $display("FAIL r_state cyc %0d got %0d exp %0d", i, state, exp_st[i]); end
            tests++; if (reg_write !== (i == 3)) begin failed++; $display("FAIL r_reg_write cyc %0d got %b", i, reg_write); end
            if (i == 2) begin
                tests++; if ({ALUOp, alu_src_a, alu_src_b} !== 6'b10_10_00) begin
                    failed++; $display("FAIL r_exec_ctrl got %b exp 101000", {ALUOp, alu_src_a, alu_src_b}); end
            end
            if (i == 3) begin
                tests++; if (result_src !== 2'b00) begin failed++; $display("FAIL r_result_src got %b exp 00", result_src); end
            end
            @(negedge clk);
        end
        #1;
        tests++; if (state !== 4'd0) begin failed++; $display("FAIL r_return got %0d exp 0", state); end
    endtask

    task automatic test_itype_jal();
        logic [6:0] ops[2] = '{7'b0010011, 7'b1101111};
        int         mid[2] = '{8, 9};
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            op = ops[k];
            @(negedge clk);
            @(negedge clk); #1;
            tests++; if (state !== 4'(mid[k])) begin failed++; $display("FAIL ij_state k%0d got %0d exp %0d", k, state, mid[k]); end
            if (k == 0) begin
                tests++; if ({ALUOp, alu_src_b} !== 4'b10_01) begin failed++; $display("FAIL i_ctrl got %b exp 1001", {ALUOp, alu_src_b}); end
            end else begin
                tests++; if (pc_write !== 1'b1) begin failed++; $display("FAIL jal_pc_write got %b exp 1", pc_write); end
                tests++; if (imm_src !== 2'b11) begin failed++; $display("FAIL jal_imm_src got %b exp 11", imm_src); end
            end
            @(negedge clk); #1;
            tests++; if (state !== 4'd7 || reg_write !== 1'b1) begin
                failed++; $display("FAIL ij_aluwb k%0d got state %0d rw %b exp 7 1", k, state, reg_write); end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_reset();
        op = 7'b0100011; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        tests++; if (state !== 4'd2) begin failed++; $display("FAIL sw_memadr got %0d exp 2", state); end
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++; if (state !== 4'd5) begin failed++; $display("FAIL sw_state cyc %0d got %0d exp 5", i, state); end
            tests++; if ({mem_req, mem_write, adr_src} !== 3'b111) begin
                failed++; $display("FAIL sw_hold cyc %0d got %b exp 111", i, {mem_req, mem_write, adr_src}); end
            @(negedge clk);
        end
        rst = 1'b1; #1;
        tests++; if ({mem_req, mem_write} !== 2'b00) begin failed++; $display("FAIL sw_rst_drop got %b exp 00", {mem_req, mem_write}); end
        @(negedge clk);
        rst = 1'b0; #1;
        tests++; if (state !== 4'd0) begin failed++; $display("FAIL sw_rst_state got %0d exp 0", state); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        op = 7'b0000000; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            #1;
            tests++; if (state !== 4'd11 || illegal !== 1'b1) begin
                failed++; $display("FAIL trap_hold cyc %0d got state %0d ill %b exp 11 1", i, state, illegal); end
            tests++; if ({mem_req, ir_write, pc_write, reg_write} !== 4'b0000) begin
                failed++; $display("FAIL trap_enables cyc %0d got %b exp 0000", i, {mem_req, ir_write, pc_write, reg_write}); end
            @(negedge clk);
        end
        rst = 1'b1; #1;
        tests++; if (illegal !== 1'b0) begin failed++; $display("FAIL trap_rst got %b exp 0", illegal); end
        @(negedge clk);
        rst = 1'b0; #1;
        tests++; if (state !== 4'd0) begin failed++; $display("FAIL trap_exit got %0d exp 0", state); end
`else
        #1;
        tests++; if (state !== 4'd0 || illegal !== 1'b0) begin
            failed++; $display("FAIL nop_state got state %0d ill %b exp 0 0", state, illegal); end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_fetch_stall();
        test_beq();
        test_rtype();
        test_itype_jal();
        test_sw_reset();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
